// File: rtl/edge_evt_pkg.sv
// Shared types and the round-robin pick helper for the edge event arbiter.
package edge_evt_pkg;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'b00,
        EDGE_FALL = 2'b01,
        EDGE_BOTH = 2'b10,
        EDGE_NONE = 2'b11
    } edge_mode_e;

    // Widest channel count the pick helper can scan.
    localparam int unsigned MAX_CH = 32;

    typedef struct packed {
        logic        found;
        int unsigned idx;
    } rr_pick_t;

    // First set bit of pend at or above ptr, wrapping at n_ch.
    function automatic rr_pick_t rr_pick(input logic [MAX_CH-1:0] pend,
                                         input int unsigned       ptr,
                                         input int unsigned       n_ch);
        rr_pick_t    r;
        int unsigned k;
        r.found = 1'b0;
        r.idx   = 0;
        for (int unsigned off = 0; off < MAX_CH; off++) begin
            if (off < n_ch && !r.found) begin
                k = ptr + off;
                if (k >= n_ch) k = k - n_ch;
                if (pend[k[4:0]]) begin
                    r.found = 1'b1;
                    r.idx   = k;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/edge_capture_ch.sv
// One monitored channel: edge history, edge detect, pending flag, sticky overflow.
module edge_capture_ch
    import edge_evt_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sig,
    input  edge_mode_e mode_i,
    input  logic       grant_i,
    input  logic       ovf_clr_i,
    output logic       pend,
    output logic       ovf
);

    logic sig_d;
    logic det;

    // Edge detect against the previous sample according to the selected mode.
    always_comb begin
        det = 1'b0;
        unique case (mode_i)
            EDGE_RISE: det = sig & ~sig_d;
            EDGE_FALL: det = ~sig & sig_d;
            EDGE_BOTH: det = sig ^ sig_d;
            EDGE_NONE: det = 1'b0;
            default:   det = 1'b0;
        endcase
    end

    // History always tracks the input so a mode change sees no stale edge;
    // a new edge outranks the grant that clears the current one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_d <= 1'b0;
            pend  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            sig_d <= sig;
            if (mode_i == EDGE_NONE) pend <= 1'b0;
            else if (det)            pend <= 1'b1;
            else if (grant_i)        pend <= 1'b0;
            if (det && pend && !grant_i) ovf <= 1'b1;
            else if (ovf_clr_i)          ovf <= 1'b0;
        end
    end

endmodule

// File: rtl/edge_event_arbiter.sv
// Per-channel edge capture shared onto one valid/ready port by round-robin.
module edge_event_arbiter
    import edge_evt_pkg::*;
#(
    parameter  int unsigned N_CH = 4,
    localparam int unsigned CH_W = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_CH-1:0]   sig,
    input  logic [2*N_CH-1:0] mode,
    output logic              evt_valid,
    output logic [CH_W-1:0]   evt_ch,
    input  logic              evt_ready,
    output logic [N_CH-1:0]   ovf,
    input  logic [N_CH-1:0]   ovf_clr
);

    logic [N_CH-1:0] pend;
    logic [N_CH-1:0] grant;
    logic [CH_W-1:0] rr_ptr;
    logic [CH_W-1:0] winner;
    logic [CH_W-1:0] next_ptr;
    logic            load;
    rr_pick_t        pick;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        edge_capture_ch u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .sig       (sig[i]),
            .mode_i    (edge_mode_e'(mode[2*i +: 2])),
            .grant_i   (grant[i]),
            .ovf_clr_i (ovf_clr[i]),
            .pend      (pend[i]),
            .ovf       (ovf[i])
        );
    end

    // Arbitrate over registered pend only; grant one channel whenever the stage can load.
    always_comb begin
        load     = ~evt_valid | evt_ready;
        pick     = rr_pick(MAX_CH'(pend), 32'(rr_ptr), N_CH);
        winner   = CH_W'(pick.idx % N_CH);
        next_ptr = (winner == CH_W'(N_CH - 1)) ? '0 : winner + 1'b1;
        grant    = '0;
        if (load && pick.found) grant[winner] = 1'b1;
    end

    // Output stage: hold under backpressure, otherwise present the winner or go idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_valid <= 1'b0;
            evt_ch    <= '0;
            rr_ptr    <= '0;
        end else if (load) begin
            if (pick.found) begin
                evt_valid <= 1'b1;
                evt_ch    <= winner;
                rr_ptr    <= next_ptr;
            end else begin
                evt_valid <= 1'b0;
            end
        end
    end

endmodule
